difftest_commit_gen: RTL

- Producer side of the difftest commit interface. Sits at the CPU writeback stage.
- Accepts retiring-instruction records and buffers them in a small FIFO.
- Maintains a shadow architectural GPR file and drives pc/debug_pc/gpr_wire/inst_commit/cpu_ebreak_sign, one commit per cycle, toward the difftest commit consumer.
- Consumer throttles via data_ok_ok.

---
 rtl/difftest_commit_gen_if.sv | 31 +++
 rtl/difftest_commit_gen.sv | 136 +++++++++++++
 2 files changed

// File: rtl/difftest_commit_gen_if.sv
// Writeback-record and commit-side signals of the difftest commit generator.
// The master modport is the generator's own view; the slave modport is the CPU and consumer side.
interface difftest_commit_gen_if #(
    parameter int XLEN = 64,
    parameter int NREG = 32
);
    logic                 wb_valid;
    logic                 wb_ready;
    logic [XLEN-1:0]      wb_pc;
    logic [XLEN-1:0]      wb_npc;
    logic                 wb_wen;
    logic [4:0]           wb_rd;
    logic [XLEN-1:0]      wb_wdata;
    logic                 wb_ebreak;
    logic                 data_ok_ok;
    logic                 inst_commit;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      debug_pc;
    logic [XLEN*NREG-1:0] gpr_wire;
    logic                 cpu_ebreak_sign;

    modport master (
        input  wb_valid, wb_pc, wb_npc, wb_wen, wb_rd, wb_wdata, wb_ebreak, data_ok_ok,
        output wb_ready, inst_commit, pc, debug_pc, gpr_wire, cpu_ebreak_sign
    );

    modport slave (
        output wb_valid, wb_pc, wb_npc, wb_wen, wb_rd, wb_wdata, wb_ebreak, data_ok_ok,
        input  wb_ready, inst_commit, pc, debug_pc, gpr_wire, cpu_ebreak_sign
    );
endinterface

// File: rtl/difftest_commit_gen.sv
// Buffers retiring-instruction records and emits one difftest commit per cycle with a shadow GPR file.
// Define DIFFTEST_COMMIT_CNT_EN to add the 64-bit commit_cnt output.
module difftest_commit_gen #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64,
    parameter int NREG  = 32
) (
    input logic clock,
    input logic reset,
    difftest_commit_gen_if.master bus
`ifdef DIFFTEST_COMMIT_CNT_EN
    ,
    output logic [63:0] commit_cnt
`endif
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] npc;
        logic            wen;
        logic [4:0]      rd;
        logic [XLEN-1:0] wdata;
        logic            ebreak;
    } rec_t;

    rec_t            mem [DEPTH];
    rec_t            head;
    rec_t            wb_rec;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            halted_q, halted_d;
    logic            commit_q, commit_d;
    logic            ebreak_q, ebreak_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] dpc_q, dpc_d;
    logic            full, empty, push, pop;

    assign full         = (count_q == (AW+1)'(DEPTH));
    assign empty        = (count_q == '0);
    assign bus.wb_ready = !full && !halted_q && !reset;
    assign push         = bus.wb_valid && bus.wb_ready;
    assign pop          = !empty && bus.data_ok_ok && !halted_q;
    assign head         = mem[rd_ptr_q];
    assign wb_rec       = {bus.wb_pc, bus.wb_npc, bus.wb_wen, bus.wb_rd, bus.wb_wdata, bus.wb_ebreak};

    // Head is read combinationally so a record can commit on the edge after its push.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q] <= wb_rec;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        halted_d = halted_q;
        commit_d = pop;
        ebreak_d = pop && head.ebreak;
        pc_d     = pc_q;
        dpc_d    = dpc_q;
        if (pop) begin
            pc_d  = head.pc;
            dpc_d = head.npc;
        end
        // Popping an ebreak halts and drops everything still queued, including a same-edge push.
        if (pop && head.ebreak) begin
            halted_d = 1'b1;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            halted_q <= 1'b0;
            commit_q <= 1'b0;
            ebreak_q <= 1'b0;
            pc_q     <= '0;
            dpc_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            halted_q <= halted_d;
            commit_q <= commit_d;
            ebreak_q <= ebreak_d;
            pc_q     <= pc_d;
            dpc_q    <= dpc_d;
        end
    end

    assign bus.inst_commit     = commit_q;
    assign bus.cpu_ebreak_sign = ebreak_q;
    assign bus.pc              = pc_q;
    assign bus.debug_pc        = dpc_q;

    // x0 has no storage and reads as zero.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_gpr
        if (gi == 0) begin : g_x0
            assign bus.gpr_wire[XLEN-1:0] = '0;
        end else begin : g_reg
            logic [XLEN-1:0] gpr_q;
            always_ff @(posedge clock) begin
                if (reset) begin
                    gpr_q <= '0;
                end else if (pop && head.wen && (head.rd == 5'(gi))) begin
                    gpr_q <= head.wdata;
                end
            end
            assign bus.gpr_wire[XLEN*gi +: XLEN] = gpr_q;
        end
    end

`ifdef DIFFTEST_COMMIT_CNT_EN
    logic [63:0] cnt_q;
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (pop) begin
            cnt_q <= cnt_q + 64'd1;
        end
    end
    assign commit_cnt = cnt_q;
`endif
endmodule
